cmp_search_ctrl: RTL and testbench

Binary-search initiator for the 3-flag signed magnitude comparator (agtb/aeqb/altb).
- Drives the comparator's b operand (probe) and samples its flags each cycle.
- Resolves the signed value on the comparator's a operand in at most WIDTH+1 probes.
- Used for self-test of the comparator and for value discovery in the lab datapath.

---
 rtl/cmp_search_if.sv | 46 ++++
 rtl/cmp_search_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cmp_search_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_search_if.sv
// Handshake and data bundle between the binary-search controller and the
// signed magnitude comparator it drives.
// The optional abort input exists only when CMP_SEARCH_ABORT_EN is defined.
interface cmp_search_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 3
);
    logic              start;
    logic              agtb;
    logic              aeqb;
    logic              altb;
`ifdef CMP_SEARCH_ABORT_EN
    logic              abort;
`endif
    logic [WIDTH-1:0]  probe;
    logic              busy;
    logic              done;
    logic              found;
    logic              err;
    logic [WIDTH-1:0]  result;
    logic [STEP_W-1:0] steps;

`ifdef CMP_SEARCH_ABORT_EN
    // Controller side
    modport master (
        input  start, agtb, aeqb, altb, abort,
        output probe, busy, done, found, err, result, steps
    );
    // Comparator / requester side
    modport slave (
        output start, agtb, aeqb, altb, abort,
        input  probe, busy, done, found, err, result, steps
    );
`else
    // Controller side
    modport master (
        input  start, agtb, aeqb, altb,
        output probe, busy, done, found, err, result, steps
    );
    // Comparator / requester side
    modport slave (
        output start, agtb, aeqb, altb,
        input  probe, busy, done, found, err, result, steps
    );
`endif
endinterface

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator for a 3-flag signed magnitude comparator.
// Drives the comparator's b operand (probe), samples agtb/aeqb/altb on the
// following edge and narrows a signed [lo, hi] window until the value on
// the comparator's a operand is hit, or the flags prove inconsistent.
// Optional feature: define CMP_SEARCH_ABORT_EN to add an abort input that
// cancels a running search (reported as err).
module cmp_search_ctrl #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    cmp_search_if.master bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_t;

    // Window bounds carry one extra bit so that probe-1 / probe+1 at the
    // range edges cannot wrap; an emptied window then shows up as lo > hi.
    localparam logic signed [WIDTH:0] LO_INIT = {2'b11, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH:0] HI_INIT = {2'b00, {(WIDTH-1){1'b1}}};

    state_t                   state_reg,  state_next;
    logic signed [WIDTH:0]    lo_reg,     lo_next;
    logic signed [WIDTH:0]    hi_reg,     hi_next;
    logic [WIDTH-1:0]         probe_reg,  probe_next;
    logic                     done_reg,   done_next;
    logic                     found_reg,  found_next;
    logic                     err_reg,    err_next;
    logic [WIDTH-1:0]         result_reg, result_next;
    logic [STEP_W-1:0]        steps_reg,  steps_next;

    logic [2:0]               flags;
    logic                     flags_onehot;
    logic signed [WIDTH:0]    probe_ext;
    logic signed [WIDTH:0]    narrow_lo;
    logic signed [WIDTH:0]    narrow_hi;

    // Floor of the window midpoint; the sum needs two guard bits.
    function automatic logic [WIDTH-1:0] mid_of(
        input logic signed [WIDTH:0] lo,
        input logic signed [WIDTH:0] hi
    );
        logic signed [WIDTH+1:0] sum;
        sum = (WIDTH+2)'(lo) + (WIDTH+2)'(hi);
        return WIDTH'(sum >>> 1);
    endfunction

    assign flags        = {bus.agtb, bus.aeqb, bus.altb};
    assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) ||
                          (flags == 3'b001);
    assign probe_ext    = (WIDTH+1)'($signed(probe_reg));

    // State and datapath registers; reset drops any search in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            lo_reg     <= '0;
            hi_reg     <= '0;
            probe_reg  <= '0;
            done_reg   <= 1'b0;
            found_reg  <= 1'b0;
            err_reg    <= 1'b0;
            result_reg <= '0;
            steps_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            lo_reg     <= lo_next;
            hi_reg     <= hi_next;
            probe_reg  <= probe_next;
            done_reg   <= done_next;
            found_reg  <= found_next;
            err_reg    <= err_next;
            result_reg <= result_next;
            steps_reg  <= steps_next;
        end
    end

    // Next-state logic: launch from IDLE, narrow the window while probing.
    always_comb begin
        state_next  = state_reg;
        lo_next     = lo_reg;
        hi_next     = hi_reg;
        probe_next  = probe_reg;
        done_next   = 1'b0;
        found_next  = found_reg;
        err_next    = err_reg;
        result_next = result_reg;
        steps_next  = steps_reg;
        narrow_lo   = lo_reg;
        narrow_hi   = hi_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    lo_next    = LO_INIT;
                    hi_next    = HI_INIT;
                    probe_next = mid_of(LO_INIT, HI_INIT);
                    steps_next = STEP_W'(1);
                    found_next = 1'b0;
                    err_next   = 1'b0;
                    state_next = PROBE;
                end
            end

            PROBE: begin
`ifdef CMP_SEARCH_ABORT_EN
                if (bus.abort) begin
                    found_next = 1'b0;
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else
`endif
                if (!flags_onehot) begin
                    // A broken comparator: report and stop.
                    found_next = 1'b0;
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (bus.aeqb) begin
                    found_next  = 1'b1;
                    result_next = probe_reg;
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end else begin
                    if (bus.altb) begin
                        narrow_hi = probe_ext - (WIDTH+1)'(1);
                    end else begin
                        narrow_lo = probe_ext + (WIDTH+1)'(1);
                    end

                    if (narrow_lo > narrow_hi) begin
                        // Window exhausted without a match.
                        found_next = 1'b0;
                        err_next   = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        lo_next    = narrow_lo;
                        hi_next    = narrow_hi;
                        probe_next = mid_of(narrow_lo, narrow_hi);
                        steps_next = steps_reg + STEP_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.probe  = probe_reg;
    assign bus.busy   = (state_reg == PROBE);
    assign bus.done   = done_reg;
    assign bus.found  = found_reg;
    assign bus.err    = err_reg;
    assign bus.result = result_reg;
    assign bus.steps  = steps_reg;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl with a behavioural comparator on the
// probe bus. Expected search outcomes and probe sequences are queued when a
// search is launched and checked as the controller produces them.
module tb_cmp_search_ctrl;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 3;

    typedef struct {
        logic              found;
        logic              err;
        logic [WIDTH-1:0]  result;
        logic [STEP_W-1:0] steps;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cmp_search_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    cmp_search_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Comparator model, with an override for injecting bad flag patterns.
    logic signed [WIDTH-1:0] a_val = '0;
    logic                    force_en = 1'b0;
    logic [2:0]              force_flags = 3'b000;
    logic                    gt, eq, lt;

    always_comb begin
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b0;
        if (force_en) begin
            {gt, eq, lt} = force_flags;
        end else begin
            gt = (a_val >  $signed(bus.probe));
            eq = (a_val == $signed(bus.probe));
            lt = (a_val <  $signed(bus.probe));
        end
    end

    assign bus.agtb = gt;
    assign bus.aeqb = eq;
    assign bus.altb = lt;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] probe_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic f, input logic e, input logic [WIDTH-1:0] r,
                            input logic [STEP_W-1:0] s);
        exp_t x;
        x.found  = f;
        x.err    = e;
        x.result = r;
        x.steps  = s;
        exp_q.push_back(x);
    endtask

    // Step cycle by cycle until done: probes are matched against the queue,
    // the outcome against the scoreboard, then done must drop next cycle.
    task automatic run_until_done(input string tag, input int budget, output int cycles);
        bit seen;
        exp_t x;
        logic [WIDTH-1:0] ep;
        seen   = 1'b0;
        cycles = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                if (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    check({tag, ".found"},  32'(bus.found),  32'(x.found));
                    check({tag, ".err"},    32'(bus.err),    32'(x.err));
                    check({tag, ".result"}, 32'(bus.result), 32'(x.result));
                    check({tag, ".steps"},  32'(bus.steps),  32'(x.steps));
                    check({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
                end else begin
                    check({tag, ".unexpected_done"}, 32'd1, 32'd0);
                end
                check({tag, ".probes_left"}, 32'(probe_q.size()), 32'd0);
                @(posedge clk); #1;
                check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
            end else begin
                if (bus.busy === 1'b1) begin
                    ep = (probe_q.size() > 0) ? probe_q.pop_front() : 'x;
                    check({tag, ".probe"}, 32'(bus.probe), 32'(ep));
                end
                @(posedge clk); #1;
                cycles++;
            end
        end
        if (!seen) check({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    // Pulse start for one cycle; leaves the bench 1 time unit after the
    // edge that sampled it.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".probe"},  32'(bus.probe),  32'd0);
        check({tag, ".busy"},   32'(bus.busy),   32'd0);
        check({tag, ".done"},   32'(bus.done),   32'd0);
        check({tag, ".found"},  32'(bus.found),  32'd0);
        check({tag, ".err"},    32'(bus.err),    32'd0);
        check({tag, ".result"}, 32'(bus.result), 32'd0);
        check({tag, ".steps"},  32'(bus.steps),  32'd0);
    endtask

    initial begin
        int cyc;
        bus.start = 1'b0;
`ifdef CMP_SEARCH_ABORT_EN
        bus.abort = 1'b0;
`endif
        // Reset state
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle.busy", 32'(bus.busy), 32'd0);

        // a = 7: full-length search along the upper edge
        a_val   = 4'sd7;
        probe_q = '{4'hF, 4'h3, 4'h5, 4'h6, 4'h7};
        push_exp(1'b1, 1'b0, 4'h7, 3'd5);
        pulse_start();
        run_until_done("a7", 20, cyc);
        $display("search a=7: %0d cycles", cyc);

        // a = -8: most negative value
        a_val   = -4'sd8;
        probe_q = '{4'hF, 4'hB, 4'h9, 4'h8};
        push_exp(1'b1, 1'b0, 4'h8, 3'd4);
        pulse_start();
        run_until_done("a-8", 20, cyc);
        $display("search a=-8: %0d cycles", cyc);

        // a = -1: first probe hits, done one edge after start is taken
        a_val   = -4'sd1;
        probe_q = '{4'hF};
        push_exp(1'b1, 1'b0, 4'hF, 3'd1);
        pulse_start();
        run_until_done("a-1", 20, cyc);
        check("a-1.latency", 32'(cyc), 32'd1);
        $display("search a=-1: %0d cycles", cyc);

        // Bad flags 000 on the first probe: err, result held from before
        force_en    = 1'b1;
        force_flags = 3'b000;
        probe_q     = '{4'hF};
        push_exp(1'b0, 1'b1, 4'hF, 3'd1);
        pulse_start();
        run_until_done("flags000", 20, cyc);
        $display("search flags=000: %0d cycles", cyc);

        // Bad flags 101
        force_flags = 3'b101;
        probe_q     = '{4'hF};
        push_exp(1'b0, 1'b1, 4'hF, 3'd1);
        pulse_start();
        run_until_done("flags101", 20, cyc);
        force_en = 1'b0;
        $display("search flags=101: %0d cycles", cyc);

        // a = 5 with reset in the third probe cycle
        a_val = 4'sd5;
        pulse_start();
        check("rst5.p1", 32'(bus.probe), 32'hF);
        @(posedge clk); #1;
        check("rst5.p2", 32'(bus.probe), 32'h3);
        @(posedge clk); #1;
        check("rst5.p3", 32'(bus.probe), 32'h5);
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst5.idle_busy", 32'(bus.busy), 32'd0);
        check("rst5.idle_done", 32'(bus.done), 32'd0);
        $display("search a=5: reset mid-search");

        probe_q = '{4'hF, 4'h3, 4'h5};
        push_exp(1'b1, 1'b0, 4'h5, 3'd3);
        pulse_start();
        run_until_done("a5", 20, cyc);
        $display("search a=5 after reset: %0d cycles", cyc);

        // a = 2 with start held high: no restart while busy, relaunch on done
        a_val     = 4'sd2;
        probe_q   = '{4'hF, 4'h3, 4'h1, 4'h2};
        push_exp(1'b1, 1'b0, 4'h2, 3'd4);
        bus.start = 1'b1;
        @(posedge clk); #1;
        run_until_done("hold1", 20, cyc);
        check("hold.relaunch_busy",  32'(bus.busy),  32'd1);
        check("hold.relaunch_found", 32'(bus.found), 32'd0);
        check("hold.relaunch_err",   32'(bus.err),   32'd0);
        check("hold.relaunch_steps", 32'(bus.steps), 32'd1);
        bus.start = 1'b0;
        $display("search a=2 start held: %0d cycles", cyc);
        probe_q = '{4'hF, 4'h3, 4'h1, 4'h2};
        push_exp(1'b1, 1'b0, 4'h2, 3'd4);
        run_until_done("hold2", 20, cyc);
        $display("search a=2 relaunched: %0d cycles", cyc);

`ifdef CMP_SEARCH_ABORT_EN
        // Abort during the second probe
        a_val = 4'sd7;
        pulse_start();
        check("abort.p1", 32'(bus.probe), 32'hF);
        @(posedge clk); #1;
        check("abort.p2", 32'(bus.probe), 32'h3);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort.done",  32'(bus.done),  32'd1);
        check("abort.busy",  32'(bus.busy),  32'd0);
        check("abort.err",   32'(bus.err),   32'd1);
        check("abort.found", 32'(bus.found), 32'd0);
        check("abort.steps", 32'(bus.steps), 32'd2);
        $display("search a=7 aborted");
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
